// File: rtl/cg_vector_writeback.sv
// cg_vector_writeback: sequences CG ALU result words into vector memory at linear addresses and reports frame completion.
// Ports: clk, reset (sync, active-high), start (frame pulse), vec_in/vec_we (ALU word and strobe),
// mem_we/mem_addr/mem_data (registered memory write), busy, done, words_written, err_stray_we (sticky), bank.
// Optional macro WB_PINGPONG_EN: alternates the frame base between 0 and WORDS and toggles bank per completed frame.
module cg_vector_writeback #(
  parameter int number_of_clusters              = 40,
  parameter int number_of_equations_per_cluster = 19,
  parameter int element_width                   = 32,
  parameter int no_of_units                     = 8,
  parameter int memories_address_width          = 20
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [no_of_units*element_width-1:0]   vec_in,
  input  logic                                   vec_we,
  output logic                                   mem_we,
  output logic [memories_address_width-1:0]      mem_addr,
  output logic [no_of_units*element_width-1:0]   mem_data,
  output logic                                   busy,
  output logic                                   done,
  output logic [31:0]                            words_written,
  output logic                                   err_stray_we,
  output logic                                   bank
);
  localparam int N     = number_of_clusters * number_of_equations_per_cluster;
  localparam int WORDS = (N + no_of_units - 1) / no_of_units;
  localparam int AW    = memories_address_width;
  localparam int DW    = no_of_units * element_width;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d, k;
  logic            accept, last;
  logic            err_q, err_d, bank_q, bank_d, mem_we_q;
  logic [AW-1:0]   base, addr_q;
  logic [DW-1:0]   masked, data_q;
  // A start coincident with a strobe makes that strobe word 0 of the new frame.
  always_comb begin
    accept  = vec_we && (start || state_q == ACTIVE);
    k       = start ? 32'd0 : cnt_q;
    last    = accept && k == 32'(WORDS - 1);
    state_d = last ? DONE : start ? ACTIVE : state_q;
    cnt_d   = start ? {31'd0, accept} : cnt_q + {31'd0, accept};
    err_d   = start ? 1'b0 : err_q | (vec_we && state_q != ACTIVE);
`ifdef WB_PINGPONG_EN
    bank_d  = bank_q ^ last;
    base    = bank_q ? AW'(WORDS) : '0;
`else
    bank_d  = 1'b0;
    base    = '0;
`endif
  end
  // Lanes past element N exist only in the last word; their zeroing is fixed at elaboration.
  for (genvar i = 0; i < no_of_units; i++) begin : g_lane
    localparam bit PAD = ((WORDS - 1) * no_of_units + i) >= N;
    assign masked[i*element_width +: element_width] =
      (PAD && k == 32'(WORDS - 1)) ? '0 : vec_in[i*element_width +: element_width];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      bank_q   <= 1'b0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      bank_q   <= bank_d;
      mem_we_q <= accept;
      if (accept) begin
        addr_q <= base + AW'(k);
        data_q <= masked;
      end
    end
  end
  assign mem_we        = mem_we_q;
  assign mem_addr      = addr_q;
  assign mem_data      = data_q;
  assign busy          = state_q == ACTIVE;
  assign done          = state_q == DONE;
  assign words_written = cnt_q;
  assign err_stray_we  = err_q;
  assign bank          = bank_q;
endmodule

// File: tb/tb_cg_vector_writeback.sv
// tb_cg_vector_writeback: scoreboard bench for cg_vector_writeback with a short-vector instance for lane masking.
module tb_cg_vector_writeback;
  logic         clk = 1'b0, reset, start, vec_we, mem_we, busy, done, err_stray_we, bank;
  logic [255:0] vec_in, mem_data;
  logic [19:0]  mem_addr;
  logic [31:0]  words_written;
  logic         start2, vec_we2, mem_we2, busy2, done2, err2, bank2;
  logic [255:0] vec_in2, mem_data2;
  logic [19:0]  mem_addr2;
  logic [31:0]  ww2;
  int           checks = 0, errors = 0;
  logic         exp_bank = 1'b0;
  logic [275:0] sb[$];
  always #5 clk = ~clk;
  cg_vector_writeback dut (
    .clk(clk), .reset(reset), .start(start), .vec_in(vec_in), .vec_we(vec_we),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done),
    .words_written(words_written), .err_stray_we(err_stray_we), .bank(bank));
  cg_vector_writeback #(.number_of_clusters(4), .number_of_equations_per_cluster(5)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .vec_in(vec_in2), .vec_we(vec_we2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_data(mem_data2), .busy(busy2), .done(done2),
    .words_written(ww2), .err_stray_we(err2), .bank(bank2));
  function automatic logic [255:0] mk(int k);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'(k * 8 + i);
    return v;
  endfunction
  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(int k, bit st);
    logic [19:0] a;
`ifdef WB_PINGPONG_EN
    a = (exp_bank ? 20'd95 : 20'd0) + 20'(k);
`else
    a = 20'(k);
`endif
    start = st;
    vec_we = 1'b1;
    vec_in = mk(k);
    sb.push_back({a, mk(k)});
    tick();
    start = 1'b0;
    vec_we = 1'b0;
    if (k == 94) exp_bank = ~exp_bank;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_bank = 1'b0;
  endtask
  task automatic end_frame(string tag);
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_words"}, words_written, 95);
`ifdef WB_PINGPONG_EN
    chk({tag, "_bank"}, bank, exp_bank);
`else
    chk({tag, "_bank"}, bank, 0);
`endif
  endtask
  always @(negedge clk) begin
    if (mem_we) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr %0h expected no write", mem_addr);
      end else begin
        logic [275:0] e;
        e = sb.pop_front();
        if (mem_addr !== e[275:256] || mem_data !== e[255:0]) begin
          errors++;
          $display("FAIL write got addr %0h data %0h expected addr %0h data %0h",
                   mem_addr, mem_data, e[275:256], e[255:0]);
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [255:0] last2;
    start = 0; vec_we = 0; vec_in = '0; start2 = 0; vec_we2 = 0; vec_in2 = '0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words", words_written, 0);
    chk("rst_err", err_stray_we, 0);
    chk("rst_bank", bank, 0);
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    for (int k = 0; k < 95; k++) send(k, 0);
    end_frame("t1");
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 95; k++) begin
      send(k, 0);
      tick();
      tick();
    end
    end_frame("t2");
    do_reset();
    vec_we = 1'b1;
    vec_in = 256'hDEAD;
    tick();
    vec_we = 1'b0;
    tick();
    chk("t3_err_set", err_stray_we, 1);
    chk("t3_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_err_clr", err_stray_we, 0);
    chk("t3_busy_start", busy, 1);
    chk("t3_words", words_written, 0);
    for (int k = 0; k < 40; k++) send(k, 0);
    chk("t4_words40", words_written, 40);
    send(0, 1);
    chk("t4_words_restart", words_written, 1);
    chk("t4_busy", busy, 1);
    for (int k = 1; k < 95; k++) send(k, 0);
    end_frame("t4");
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 50; k++) send(k, 0);
    reset = 1'b1;
    vec_we = 1'b1;
    vec_in = mk(50);
    tick();
    vec_we = 1'b0;
    chk("t5_mem_we", mem_we, 0);
    chk("t5_busy", busy, 0);
    chk("t5_words", words_written, 0);
    chk("t5_done", done, 0);
    reset = 1'b0;
    exp_bank = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vec_we2 = 1'b1;
      vec_in2 = mk(k);
      tick();
      vec_we2 = 1'b0;
      last2 = mk(k);
      if (k == 2) last2[255:128] = '0;
      chk($sformatf("t6_we_%0d", k), mem_we2, 1);
      chk($sformatf("t6_data_%0d", k), mem_data2, last2);
    end
    chk("t6_done", done2, 1);
    chk("t6_words", ww2, 3);
    tick();
    chk("t6_idle_we", mem_we2, 0);
    repeat (3) tick();
    chk("sb_empty", 256'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
